// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM compare / dead-time slice.
//   PWM_WIDTH_DEF       default carrier and duty width in bits
//   PWM_DEAD_CYCLES_DEF default dead-time length in clk cycles (1..15)
//   PWM_CNT_W           dead counter width, wide enough for 15
//   pwm_state_t         dead-time FSM state encoding
package pwm_pkg;

   localparam int PWM_WIDTH_DEF       = 6;
   localparam int PWM_DEAD_CYCLES_DEF = 2;
   localparam int PWM_CNT_W           = 4;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_HIGH_ON,
      ST_DEAD_TO_H,
      ST_LOW_ON,
      ST_DEAD_TO_L
   } pwm_state_t;

endpackage

// File: rtl/pwm_compare_deadtime_if.sv
// pwm_compare_deadtime_if: carrier / duty-update bus between the carrier
// generator plus duty source (master) and the PWM compare block (slave).
//   carrier    triangle count, 0..2^WIDTH-1 up/down
//   duty       requested compare level
//   duty_valid one-cycle strobe qualifying duty
//   duty_upd   one-cycle pulse when a pending duty becomes active
interface pwm_compare_deadtime_if
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH_DEF
);
   logic [WIDTH-1:0] carrier;
   logic [WIDTH-1:0] duty;
   logic             duty_valid;
   logic             duty_upd;

   modport master (output carrier, output duty, output duty_valid, input duty_upd);
   modport slave  (input carrier, input duty, input duty_valid, output duty_upd);
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate-drive FSM with dead-time insertion.
//   clk, rst_n  clock and asynchronous active-low reset
//   valley      carrier at 0; releases the FSM out of OFF
//   demand      1 = high side wanted, 0 = low side wanted
//   kill        forces both outputs low and returns to OFF on the next edge
//   pwm_h/pwm_l registered gate drives, never high together
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DEAD_CYCLES = PWM_DEAD_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valley,
   input  logic demand,
   input  logic kill,
   output logic pwm_h,
   output logic pwm_l
);

   localparam logic [PWM_CNT_W-1:0] RELOAD = PWM_CNT_W'(DEAD_CYCLES - 1);

   pwm_state_t           state_reg;
   logic [PWM_CNT_W-1:0] cnt_reg;
   logic                 pwm_h_reg;
   logic                 pwm_l_reg;

   // Outputs are registered together with the state, so a side only drives
   // in the ON state that was entered on this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_OFF;
         cnt_reg   <= '0;
         pwm_h_reg <= 1'b0;
         pwm_l_reg <= 1'b0;
      end else begin
         pwm_h_reg <= 1'b0;
         pwm_l_reg <= 1'b0;
         if (kill) begin
            state_reg <= ST_OFF;
            cnt_reg   <= '0;
         end else begin
            case (state_reg)
               ST_OFF: begin
                  if (valley) begin
                     state_reg <= demand ? ST_DEAD_TO_H : ST_DEAD_TO_L;
                     cnt_reg   <= RELOAD;
                  end
               end
               ST_HIGH_ON: begin
                  if (!demand) begin
                     state_reg <= ST_DEAD_TO_L;
                     cnt_reg   <= RELOAD;
                  end else begin
                     pwm_h_reg <= 1'b1;
                  end
               end
               ST_LOW_ON: begin
                  if (demand) begin
                     state_reg <= ST_DEAD_TO_H;
                     cnt_reg   <= RELOAD;
                  end else begin
                     pwm_l_reg <= 1'b1;
                  end
               end
               ST_DEAD_TO_H: begin
                  // A reversal restarts the full gap toward the other side.
                  if (!demand) begin
                     state_reg <= ST_DEAD_TO_L;
                     cnt_reg   <= RELOAD;
                  end else if (cnt_reg == '0) begin
                     state_reg <= ST_HIGH_ON;
                     pwm_h_reg <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg - PWM_CNT_W'(1);
                  end
               end
               ST_DEAD_TO_L: begin
                  if (demand) begin
                     state_reg <= ST_DEAD_TO_H;
                     cnt_reg   <= RELOAD;
                  end else if (cnt_reg == '0) begin
                     state_reg <= ST_LOW_ON;
                     pwm_l_reg <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg - PWM_CNT_W'(1);
                  end
               end
               default: begin
                  state_reg <= ST_OFF;
                  cnt_reg   <= '0;
               end
            endcase
         end
      end
   end

   assign pwm_h = pwm_h_reg;
   assign pwm_l = pwm_l_reg;

endmodule

// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime: shadowed duty compare against an up/down carrier,
// driving a complementary gate pair through a dead-time FSM.
//   clk, rst_n     clock and asynchronous active-low reset
//   bus (slave)    carrier, duty, duty_valid in; duty_upd out
//   pwm_h, pwm_l   registered high/low side gate drives
// Optional feature, macro PWM_FAULT_EN: adds fault, fault_clr inputs and
// the fault_latched output; a fault kills both gates until cleared, then
// the FSM restarts at the next carrier valley.
module pwm_compare_deadtime
   import pwm_pkg::*;
#(
   parameter int WIDTH       = PWM_WIDTH_DEF,
   parameter int DEAD_CYCLES = PWM_DEAD_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pwm_compare_deadtime_if.slave  bus,
`ifdef PWM_FAULT_EN
   input  logic                   fault,
   input  logic                   fault_clr,
   output logic                   fault_latched,
`endif
   output logic                   pwm_h,
   output logic                   pwm_l
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] pending_reg;
   logic [WIDTH-1:0] active_reg;
   logic             outstanding_reg;
   logic             duty_upd_reg;
   logic             valley;
   logic             demand;
   logic             kill;

   assign valley = (bus.carrier == '0);

   // Duty is only applied at a valley so each carrier period sees one
   // consistent compare level. A strobe landing on the valley itself goes
   // straight through to active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg     <= '0;
         active_reg      <= '0;
         outstanding_reg <= 1'b0;
         duty_upd_reg    <= 1'b0;
      end else begin
         duty_upd_reg <= 1'b0;
         if (bus.duty_valid) begin
            pending_reg     <= bus.duty;
            outstanding_reg <= 1'b1;
         end
         if (valley && (outstanding_reg || bus.duty_valid)) begin
            active_reg      <= bus.duty_valid ? bus.duty : pending_reg;
            outstanding_reg <= 1'b0;
            duty_upd_reg    <= 1'b1;
         end
      end
   end

   // All-ones means 100 %: carrier reaches all-ones at the peak, where a
   // plain less-than would otherwise drop the high side for a cycle.
   assign demand = (active_reg == ALL_ONES) || (bus.carrier < active_reg);

`ifdef PWM_FAULT_EN
   logic fault_latched_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_latched_reg <= 1'b0;
      end else if (fault) begin
         fault_latched_reg <= 1'b1;
      end else if (fault_clr) begin
         fault_latched_reg <= 1'b0;
      end
   end

   // The live fault kills on the very next edge; the latch holds the FSM
   // in OFF until software clears it.
   assign kill          = fault | fault_latched_reg;
   assign fault_latched = fault_latched_reg;
`else
   assign kill = 1'b0;
`endif

   pwm_deadtime #(
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_deadtime (
      .clk    (clk),
      .rst_n  (rst_n),
      .valley (valley),
      .demand (demand),
      .kill   (kill),
      .pwm_h  (pwm_h),
      .pwm_l  (pwm_l)
   );

   assign bus.duty_upd = duty_upd_reg;

endmodule

// File: doc/pwm_compare_deadtime.md
PWM_COMPARE_DEADTIME -- requirements
Module: pwm_compare_deadtime

Interface
REQ-001 SHALL have parameter WIDTH, default 6: carrier and duty width in bits.
REQ-002 SHALL have parameter DEAD_CYCLES, default 2: dead-time length in clk cycles, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 carrier  input  WIDTH  triangle count from the upstream carrier generator (0..2^WIDTH-1, up/down).
REQ-006 duty  input  WIDTH  requested compare level.
REQ-007 duty_valid  input  1  one-cycle strobe; captures duty into the pending register.
REQ-008 pwm_h  output  1  high-side gate drive, registered.
REQ-009 pwm_l  output  1  low-side gate drive, registered.
REQ-010 duty_upd  output  1  one-cycle pulse when the pending duty is applied.

Function
REQ-011 duty_valid=1 SHALL load pending<=duty; the last strobe before a valley wins.
REQ-012 carrier==0 (valley) with a pending load outstanding SHALL copy active<=pending, clear the outstanding flag and pulse duty_upd in the same cycle.
REQ-013 duty_valid coincident with a valley SHALL use the new duty in that same transfer.
REQ-014 A valley with no outstanding load SHALL leave active unchanged and SHALL NOT pulse duty_upd.
REQ-015 Raw demand SHALL be carrier<active (unsigned), except active==all-ones forces demand=1 (100 %); active==0 gives demand=0.
REQ-016 The dead-time FSM SHALL have states OFF, HIGH_ON, DEAD_TO_H, LOW_ON, DEAD_TO_L.
REQ-017 OFF: both outputs 0; the first valley after reset SHALL move to DEAD_TO_H if demand=1, else DEAD_TO_L.
REQ-018 HIGH_ON: pwm_h=1, pwm_l=0; demand=0 SHALL go to DEAD_TO_L with dead counter loaded to DEAD_CYCLES-1.
REQ-019 LOW_ON: pwm_h=0, pwm_l=1; demand=1 SHALL go to DEAD_TO_H with dead counter loaded to DEAD_CYCLES-1.
REQ-020 DEAD_TO_x: both outputs 0; counter decrements each cycle; on reaching 0 SHALL enter x_ON.
REQ-021 If demand reverses during DEAD_TO_x, the FSM SHALL switch to the opposite DEAD state and reload the counter to DEAD_CYCLES-1.
REQ-022 pwm_h and pwm_l SHALL never both be 1 in any cycle.
REQ-023 Latency: a demand change SHALL produce the dead gap beginning on the next clk edge; the new side SHALL assert exactly DEAD_CYCLES+1 cycles after the demand change.

Reset
REQ-024 rst_n=0 SHALL force, asynchronously: pwm_h=0, pwm_l=0, duty_upd=0, state=OFF, active=0, pending=0, outstanding flag=0, counter=0.
REQ-025 Reset asserted mid-dead-time or mid-period SHALL abort immediately, with no partial output pulse.

Configuration
REQ-026 Macro PWM_FAULT_EN SHALL add input fault (1 bit) and fault_clr (1 bit), and output fault_latched (1 bit).
REQ-027 With PWM_FAULT_EN defined: fault=1 SHALL drive both outputs to 0 on the next edge, set fault_latched and enter OFF; fault_clr with fault=0 SHALL clear the latch; normal operation then resumes at the next valley.
REQ-028 With PWM_FAULT_EN undefined: the fault ports SHALL be absent and behaviour SHALL be exactly as REQ-011..025.

Structure
REQ-029 Shared package pwm_pkg SHALL hold the FSM state enum, the WIDTH default and the DEAD_CYCLES default.
REQ-030 The dead-time FSM plus its counter SHALL be sub-module pwm_deadtime (inputs: demand, fault kill; outputs: pwm_h, pwm_l); the duty shadow and compare logic stay at top level.

Verification
REQ-031 Reset release; duty=32 strobed; WIDTH=6 carrier running -> outputs 0 until first valley, then pwm_h high while carrier<32 with a 2-cycle gap at each edge.
REQ-032 Duty 16 strobed at carrier=40 falling, then 48 strobed before the valley -> exactly one duty_upd at carrier==0, with active=48.
REQ-033 Duty 0 -> pwm_l constant 1 after settling; duty 63 -> pwm_h constant 1; no dead gaps in steady state.
REQ-034 Force demand to toggle twice within the dead window (duty near the carrier valley) -> counter reloads and no overlap; assert pwm_h&pwm_l==0 on every cycle.
REQ-035 With PWM_FAULT_EN: fault pulsed while pwm_h=1 -> both outputs 0 on the next edge, fault_latched=1; fault_clr -> outputs resume after the next valley.
REQ-036 rst_n dropped during DEAD_TO_H -> immediate outputs 0 and state OFF; recovery follows REQ-017.
